// File: rtl/wb_reg_file.sv
// ---------------------------------------------------------------------------
// WbRegFile (module wb_reg_file)
// Write-back stage register file: one synchronous write port fed by the
// write-back source mux, two combinational operand read ports for decode/ALU.
// The storage array has no reset; a sequential clear engine sweeps it to zero
// one entry per clock after reset release or when clr_req is seen in IDLE.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (restarts the clear sweep)
//   wb_en    write request, sampled at posedge clk
//   wb_addr  write address
//   wb_data  write data from the write-back mux
//   rs_addr  read port A address
//   rt_addr  read port B address
//   rs_data  read port A data (combinational)
//   rt_data  read port B data (combinational)
//   clr_req  start a clear sweep (only honoured in IDLE)
//   busy     high while a clear sweep is running
//   wb_drop  registered one-cycle pulse: previous cycle's write was discarded
// ---------------------------------------------------------------------------
module wb_reg_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              wb_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } sweepState_t;

  sweepState_t       state;
  logic [ADDR_W-1:0] clrIdx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic idleWrite;
  logic writeToZero;
  logic commitWrite;
  logic bypassRs;
  logic bypassRt;

  // A write only lands when the engine is idle and no clear is being started
  // in the same cycle; writes aimed at a hard-wired R0 vanish silently.
  assign idleWrite   = (state == IDLE) && wb_en && !clr_req;
  assign writeToZero = (ZERO_REG != 0) && (wb_addr == '0);
  assign commitWrite = idleWrite && !writeToZero;

  // Forwarding only applies to writes that will actually commit, so a
  // discarded write can never leak its data onto a read port.
  assign bypassRs = (BYPASS != 0) && commitWrite && (wb_addr == rs_addr);
  assign bypassRt = (BYPASS != 0) && commitWrite && (wb_addr == rt_addr);

  // Clear engine: CLEAR walks clrIdx from 0 to the last entry and then drops
  // into IDLE. clrIdx holds at the last index instead of wrapping. wb_drop
  // flags any write request that arrived while sweeping or that collided
  // with a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clrIdx  <= '0;
      busy    <= 1'b1;
      wb_drop <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          wb_drop <= wb_en;
          if (clrIdx == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clrIdx <= clrIdx + 1'b1;
          end
        end
        IDLE: begin
          wb_drop <= wb_en && clr_req;
          if (clr_req) begin
            state  <= CLEAR;
            clrIdx <= '0;
            busy   <= 1'b1;
          end
        end
        default: begin
          state   <= CLEAR;
          clrIdx  <= '0;
          busy    <= 1'b1;
          wb_drop <= 1'b0;
        end
      endcase
    end
  end

  // Storage array, deliberately without reset: the sweep zeroes one entry
  // per clock, otherwise the single write port updates one entry.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clrIdx] <= '0;
    end else if (commitWrite) begin
      mem[wb_addr] <= wb_data;
    end
  end

  // Read ports: forced to zero during a sweep (array contents are in flux),
  // R0 reads as zero when hard-wired, otherwise forwarded or stored data.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (state == IDLE) begin
      if ((ZERO_REG != 0) && (rs_addr == '0)) begin
        rs_data = '0;
      end else if (bypassRs) begin
        rs_data = wb_data;
      end else begin
        rs_data = mem[rs_addr];
      end
      if ((ZERO_REG != 0) && (rt_addr == '0)) begin
        rt_data = '0;
      end else if (bypassRt) begin
        rt_data = wb_data;
      end else begin
        rt_data = mem[rt_addr];
      end
    end
  end

endmodule

// File: tb/tb_wb_reg_file.sv
// ---------------------------------------------------------------------------
// TbWbRegFile (module tb_wb_reg_file)
// Drives two register files side by side from the same inputs: dutA with
// ZERO_REG=1/BYPASS=1 and dutB with ZERO_REG=0/BYPASS=0. A behavioural model
// tracks both arrays, the remaining sweep length and the expected drop pulse.
// ---------------------------------------------------------------------------
module tb_wb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic        clr_req;

  logic [15:0] rsDataA, rtDataA, rsDataB, rtDataB;
  logic        busyA, busyB, dropA, dropB;

  int passCount;
  int checkCount;

  logic [15:0] memA [8];
  logic [15:0] memB [8];
  int          clearLeft;
  logic        expDrop;

  wb_reg_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dutA (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rsDataA), .rt_data(rtDataA), .clr_req(clr_req),
    .busy(busyA), .wb_drop(dropA)
  );

  wb_reg_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rsDataB), .rt_data(rtDataB), .clr_req(clr_req),
    .busy(busyB), .wb_drop(dropB)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected read value: zero while sweeping, zero for hard-wired R0,
  // forwarded data for a same-cycle committing write, else stored value.
  function automatic logic [15:0] expRead(input bit variantA, input logic [2:0] addr);
    if (clearLeft > 0 || !rst_n) return 16'h0000;
    if (variantA) begin
      if (addr == 3'd0) return 16'h0000;
      if (wb_en && !clr_req && addr == wb_addr) return wb_data;
      return memA[addr];
    end
    return memB[addr];
  endfunction

  // Model update for one rising edge, using the inputs held across it.
  task automatic modelEdge();
    if (!rst_n) begin
      clearLeft = 8;
      expDrop   = 1'b0;
    end else if (clearLeft > 0) begin
      expDrop   = wb_en;
      clearLeft = clearLeft - 1;
    end else if (clr_req) begin
      expDrop   = wb_en;
      clearLeft = 8;
      for (int i = 0; i < 8; i++) begin
        memA[i] = 16'h0000;
        memB[i] = 16'h0000;
      end
    end else begin
      expDrop = 1'b0;
      if (wb_en) begin
        memB[wb_addr] = wb_data;
        if (wb_addr != 3'd0) memA[wb_addr] = wb_data;
      end
    end
  endtask

  // One comparison: counts it and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
  endtask

  task automatic checkAll();
    checkOutput("rsA", rsDataA, expRead(1'b1, rs_addr));
    checkOutput("rtA", rtDataA, expRead(1'b1, rt_addr));
    checkOutput("rsB", rsDataB, expRead(1'b0, rs_addr));
    checkOutput("rtB", rtDataB, expRead(1'b0, rt_addr));
    checkOutput("busyA", {15'd0, busyA}, {15'd0, (clearLeft > 0)});
    checkOutput("busyB", {15'd0, busyB}, {15'd0, (clearLeft > 0)});
    checkOutput("dropA", {15'd0, dropA}, {15'd0, expDrop});
    checkOutput("dropB", {15'd0, dropB}, {15'd0, expDrop});
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic applyStimulus(input logic en, input logic [2:0] wa, input logic [15:0] wd,
                               input logic [2:0] ra, input logic [2:0] rb, input logic clr);
    wb_en   = en;
    wb_addr = wa;
    wb_data = wd;
    rs_addr = ra;
    rt_addr = rb;
    clr_req = clr;
    @(negedge clk);
    checkAll();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst_n   = 1'b0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    rs_addr = '0;
    rt_addr = '0;
    clr_req = 1'b0;
    clearLeft = 8;
    expDrop   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      memA[i] = 16'h0000;
      memB[i] = 16'h0000;
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 3'd4, 16'h1111, 3'd1, 3'd2, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd1, 3'd2, 1'b0);

    // Reset release: 8-cycle sweep, then every entry reads zero.
    rst_n = 1'b1;
    idleCycles(8);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0);

    // Basic writes and same-cycle bypass.
    applyStimulus(1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd5, 16'h1234, 3'd3, 3'd1, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd3, 3'd5, 1'b0);
    applyStimulus(1'b1, 3'd3, 16'hAAAA, 3'd3, 3'd5, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0);

    // R0 write: discarded on dutA without a drop pulse, kept on dutB.
    applyStimulus(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);

    // Write colliding with a clear request, then a write during the sweep.
    applyStimulus(1'b1, 3'd2, 16'h7777, 3'd2, 3'd2, 1'b0);
    applyStimulus(1'b1, 3'd2, 16'h5555, 3'd2, 3'd3, 1'b1);
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd2, 3'd3, 1'b0);
    applyStimulus(1'b1, 3'd6, 16'h6666, 3'd6, 3'd2, 1'b1);
    idleCycles(7);
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd2, 3'd6, 1'b0);

    // Reset asserted mid-sweep at clr_idx=4; sweep restarts from scratch.
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);
    idleCycles(4);
    rst_n = 1'b0;
    clearLeft = 8;
    expDrop   = 1'b0;
    #1;
    checkOutput("busyRstA", {15'd0, busyA}, 16'd1);
    applyStimulus(1'b1, 3'd1, 16'h2222, 3'd1, 3'd1, 1'b0);
    rst_n = 1'b1;
    idleCycles(8);
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd1, 3'd7, 1'b0);

    // Back-to-back writes to all addresses, then read pairs (i, 7-i).
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), 16'hC000 + 16'(i * 16'h0101), 3'(i), 3'(7 - i), 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 24) == 0));
    end
    idleCycles(10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
